// File: rtl/axi_sram_slave_pkg.sv
// axi_sram_slave_pkg: AXI3 codes and burst bookkeeping
// shared by the AXI-to-SRAM slave.
package axi_sram_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [7:0] len;
        logic [7:0] beat;
        logic [2:0] size;
    } burst_ctx_t;

    function automatic logic [31:0] beat_step(
        input logic [2:0] size
    );
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 INCR slave on a single-port sync SRAM,
// one read and one write in flight, write wins the port.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [3:0]            arid,
    input  logic [31:0]           araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic [1:0]            arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,

    output logic [3:0]            rid,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,

    input  logic [3:0]            awid,
    input  logic [31:0]           awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic [1:0]            awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,

    input  logic [3:0]            wid,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,

    output logic [3:0]            bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,

    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int BW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_REQ,
        RD_CAP,
        RD_VALID
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    rd_state_e   rd_state;
    burst_ctx_t  rd_ctx;
    logic [BW-1:0] rd_addr;

    wr_state_e   wr_state;
    burst_ctx_t  wr_ctx;
    logic [BW-1:0] wr_addr;

    logic ar_fire;
    logic aw_fire;
    logic w_fire;
    logic rd_grant;

    assign ar_fire  = arvalid & arready;
    assign aw_fire  = awvalid & awready;
    assign w_fire   = wvalid & wready;
    assign rd_grant = (rd_state == RD_REQ) & ~w_fire;

    assign rresp = AXI_RESP_OKAY;
    assign bresp = AXI_RESP_OKAY;

    // Byte addresses wrap inside the SRAM window; the word
    // index is the byte address with the lane bits dropped.
    always_comb begin
        ram_en    = w_fire | rd_grant;
        ram_we    = w_fire ? wstrb : 4'b0000;
        ram_addr  = w_fire ? wr_addr[BW-1:2] : rd_addr[BW-1:2];
        ram_wdata = w_fire ? wdata : 32'd0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= RD_IDLE;
            rd_ctx   <= '0;
            rd_addr  <= '0;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rdata    <= 32'd0;
            rid      <= 4'd0;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (ar_fire) begin
                        rd_ctx.len  <= arlen;
                        rd_ctx.beat <= 8'd0;
                        rd_ctx.size <= arsize;
                        rd_addr     <= araddr[BW-1:0];
                        rid         <= arid;
                        arready     <= 1'b0;
                        rd_state    <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (rd_grant) begin
                        rd_state <= RD_CAP;
                    end
                end
                RD_CAP: begin
                    rdata    <= ram_rdata;
                    rlast    <= (rd_ctx.beat == rd_ctx.len);
                    rvalid   <= 1'b1;
                    rd_state <= RD_VALID;
                end
                RD_VALID: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (rlast) begin
                            arready  <= 1'b1;
                            rd_state <= RD_IDLE;
                        end else begin
                            rd_addr     <= rd_addr
                                + BW'(beat_step(rd_ctx.size));
                            rd_ctx.beat <= rd_ctx.beat + 8'd1;
                            rd_state    <= RD_REQ;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Burst length alone ends the burst; wlast is not trusted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= WR_IDLE;
            wr_ctx   <= '0;
            wr_addr  <= '0;
            awready  <= 1'b1;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= 4'd0;
        end else begin
            unique case (wr_state)
                WR_IDLE: begin
                    if (aw_fire) begin
                        wr_ctx.len  <= awlen;
                        wr_ctx.beat <= 8'd0;
                        wr_ctx.size <= awsize;
                        wr_addr     <= awaddr[BW-1:0];
                        bid         <= awid;
                        awready     <= 1'b0;
                        wready      <= 1'b1;
                        wr_state    <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_fire) begin
                        if (wr_ctx.beat == wr_ctx.len) begin
                            wready   <= 1'b0;
                            bvalid   <= 1'b1;
                            wr_state <= WR_RESP;
                        end else begin
                            wr_addr     <= wr_addr
                                + BW'(beat_step(wr_ctx.size));
                            wr_ctx.beat <= wr_ctx.beat + 8'd1;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{arburst, arlock, arcache, arprot,
                         awburst, awlock, awcache, awprot,
                         wid, wlast,
                         araddr[31:BW], awaddr[31:BW]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed vectors, corner sequences and
// randomized bursts checked against a word-array reference.
module tb_axi_sram_slave;

    localparam int AW = 16;
    localparam int NW = 1 << AW;
    localparam logic [31:0] BMASK = 32'h0003_FFFF;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = 2'b01;
    logic [1:0]  arlock = '0;
    logic [3:0]  arcache = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = 2'b01;
    logic [1:0]  awlock = '0;
    logic [3:0]  awcache = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    axi_sram_slave #(.ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 aclk = ~aclk;

    // Behavioural single-port SRAM with a bench preload port.
    logic [31:0]   mem [0:NW-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;

    always @(posedge aclk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b])
                        mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    logic [31:0] exp_mem [0:NW-1];
    int tests = 0;
    int fails = 0;
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pre;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a,
                           input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge aclk); #1;
        pl_en = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [2:0] sz);
        int n = 0;
        arvalid = 1'b1; arid = id; araddr = a;
        arlen = len; arsize = sz;
        @(negedge aclk);
        while (!arready && n < 50) begin
            @(negedge aclk); n++;
        end
        chk("ar_handshake", {31'd0, arready}, 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [2:0] sz);
        int n = 0;
        awvalid = 1'b1; awid = id; awaddr = a;
        awlen = len; awsize = sz;
        @(negedge aclk);
        while (!awready && n < 50) begin
            @(negedge aclk); n++;
        end
        chk("aw_handshake", {31'd0, awready}, 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    // rmode: 0 = always ready, 1 = toggle, 2 = random
    task automatic rd_collect(input logic [3:0] id, input logic [31:0] a,
                              input logic [7:0] len, input logic [2:0] sz,
                              input int rmode,
                              output logic [31:0] first);
        logic [31:0] addr = a & BMASK;
        logic [31:0] hd = '0;
        logic held = 1'b0;
        int beat = 0;
        int n = 0;
        first = '0;
        while (beat <= int'(len) && n < 2000) begin
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = (n % 2 == 0);
                default: rready = 1'($urandom % 2);
            endcase
            @(negedge aclk);
            if (held) begin
                chk("r_hold_valid", {31'd0, rvalid}, 32'd1);
                chk("r_hold_data", rdata, hd);
            end
            held = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    chk("r_data", rdata, exp_mem[addr[AW+1:2]]);
                    chk("r_id", {28'd0, rid}, {28'd0, id});
                    chk("r_resp", {30'd0, rresp}, 32'd0);
                    chk("r_last", {31'd0, rlast},
                        {31'd0, beat == int'(len)});
                    if (beat == 0) first = rdata;
                    addr = (addr + (32'd1 << sz)) & BMASK;
                    beat++;
                end else begin
                    held = 1'b1;
                    hd = rdata;
                end
            end
            @(posedge aclk); #1;
            n++;
        end
        rready = 1'b0;
        chk("r_timeout", n, (n < 2000) ? n : 0);
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] a,
                            input logic [7:0] len, input logic [2:0] sz,
                            input bit gaps, input int bdelay);
        logic [31:0] addr = a & BMASK;
        int beat = 0;
        int n = 0;
        int d = bdelay;
        aw_send(id, a, len, sz);
        while (beat <= int'(len) && n < 2000) begin
            if (gaps && ($urandom % 3 == 0)) begin
                wvalid = 1'b0;
            end else begin
                wvalid = 1'b1;
                wdata = wd_q[beat];
                wstrb = ws_q[beat];
                wlast = (beat == int'(len));
            end
            @(negedge aclk);
            if (wvalid && wready) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b])
                        exp_mem[addr[AW+1:2]][8*b +: 8] = wdata[8*b +: 8];
                addr = (addr + (32'd1 << sz)) & BMASK;
                beat++;
            end
            @(posedge aclk); #1;
            n++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("w_timeout", n, (n < 2000) ? n : 0);
        bready = (d == 0);
        @(negedge aclk);
        chk("b_latency", {31'd0, bvalid}, 32'd1);
        chk("b_id", {28'd0, bid}, {28'd0, id});
        chk("b_resp", {30'd0, bresp}, 32'd0);
        while (d > 0) begin
            @(posedge aclk); #1;
            d--;
            bready = (d == 0);
            @(negedge aclk);
            chk("b_hold", {31'd0, bvalid}, 32'd1);
            chk("b_hold_id", {28'd0, bid}, {28'd0, id});
        end
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        chk("b_done", {31'd0, bvalid}, 32'd0);
        @(posedge aclk); #1;
    endtask

    logic [31:0] got;
    logic        en_log [16];
    logic [3:0]  we_log [16];
    logic [AW-1:0] ad_log [16];

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'hAABB_CCDD, 4'h5, 32'h00BB_00DD};
        vecs[1] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF, 32'h1234_5678};
        vecs[2] = '{32'h0000_0020, 32'hCAFE_F00D, 32'h1234_5678, 4'h0, 32'hCAFE_F00D};
        vecs[3] = '{32'h0000_0030, 32'h0000_0000, 32'hA1B2_C3D4, 4'h8, 32'hA100_0000};
        vecs[4] = '{32'h0000_0034, 32'h5555_5555, 32'hA1B2_C3D4, 4'h3, 32'h5555_C3D4};
        vecs[5] = '{32'h0003_FFFC, 32'h1111_1111, 32'h0BAD_F00D, 4'h6, 32'h11AD_F011};

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arready", {31'd0, arready}, 32'd1);
        chk("rst_awready", {31'd0, awready}, 32'd1);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rid", {28'd0, rid}, 32'd0);
        chk("rst_rresp", {30'd0, rresp}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_bid", {28'd0, bid}, 32'd0);
        chk("rst_bresp", {30'd0, bresp}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Single read with latency check
        preload(16'h0100, 32'hDEAD_BEEF);
        arvalid = 1'b1; arid = 4'd1; araddr = 32'h400;
        arlen = 8'd0; arsize = 3'd2;
        @(negedge aclk);
        chk("lat_arready", {31'd0, arready}, 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        chk("lat_t1_ram_en", {31'd0, ram_en}, 32'd1);
        chk("lat_t1_ram_we", {28'd0, ram_we}, 32'd0);
        chk("lat_t1_ram_addr", {16'd0, ram_addr}, 32'h100);
        chk("lat_t1_rvalid", {31'd0, rvalid}, 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("lat_t2_rvalid", {31'd0, rvalid}, 32'd0);
        @(posedge aclk); #1;
        rready = 1'b1;
        @(negedge aclk);
        chk("lat_t3_rvalid", {31'd0, rvalid}, 32'd1);
        chk("lat_t3_rdata", rdata, 32'hDEAD_BEEF);
        chk("lat_t3_rid", {28'd0, rid}, 32'd1);
        chk("lat_t3_rlast", {31'd0, rlast}, 32'd1);
        chk("lat_t3_rresp", {30'd0, rresp}, 32'd0);
        @(posedge aclk); #1;
        rready = 1'b0;
        @(negedge aclk);
        chk("lat_done_rvalid", {31'd0, rvalid}, 32'd0);
        chk("lat_done_arready", {31'd0, arready}, 32'd1);
        @(posedge aclk); #1;

        // Burst write
        wd_q = {32'h11, 32'h22, 32'h33, 32'h44};
        ws_q = {4'hF, 4'hF, 4'hF, 4'hF};
        wr_burst(4'd5, 32'h1000, 8'd3, 3'd2, 1'b0, 0);
        chk("bw_mem0", mem[16'h400], 32'h11);
        chk("bw_mem1", mem[16'h401], 32'h22);
        chk("bw_mem2", mem[16'h402], 32'h33);
        chk("bw_mem3", mem[16'h403], 32'h44);

        // Vector table: single-beat strobed writes, then read back
        for (int i = 0; i < 6; i++) begin
            preload(vecs[i].addr[AW+1:2], vecs[i].pre);
            wd_q = {vecs[i].data};
            ws_q = {vecs[i].strb};
            wr_burst(4'(i), vecs[i].addr, 8'd0, 3'd2, 1'b0, i % 3);
            ar_send(4'(i + 8), vecs[i].addr, 8'd0, 3'd2);
            rd_collect(4'(i + 8), vecs[i].addr, 8'd0, 3'd2, 0, got);
            chk("vec_rdata", got, vecs[i].exp);
        end

        // Contention: AR and AW in one cycle, wvalid held high
        preload(16'h0800, 32'hFFFF_FFFF);
        begin
            int wb = 0;
            bit ar_hs, aw_hs, w_hs, b_seen, r_seen;
            logic [31:0] r_got = '0;
            b_seen = 1'b0; r_seen = 1'b0;
            arvalid = 1'b1; arid = 4'd3; araddr = 32'h2000;
            arlen = 8'd0; arsize = 3'd2;
            awvalid = 1'b1; awid = 4'd4; awaddr = 32'h2000;
            awlen = 8'd3; awsize = 3'd2;
            wvalid = 1'b1; wdata = 32'hA0; wstrb = 4'hF; wlast = 1'b0;
            bready = 1'b1; rready = 1'b1;
            for (int c = 0; c < 16; c++) begin
                @(negedge aclk);
                en_log[c] = ram_en;
                we_log[c] = ram_we;
                ad_log[c] = ram_addr;
                ar_hs = arvalid && arready;
                aw_hs = awvalid && awready;
                w_hs  = wvalid && wready;
                if (bvalid && bready) b_seen = 1'b1;
                if (rvalid && rready && !r_seen) begin
                    r_seen = 1'b1;
                    r_got = rdata;
                end
                @(posedge aclk); #1;
                if (ar_hs) arvalid = 1'b0;
                if (aw_hs) awvalid = 1'b0;
                if (w_hs) begin
                    wb++;
                    if (wb == 4) wvalid = 1'b0;
                    wdata = 32'hA0 + 32'(wb);
                    wlast = (wb == 3);
                end
            end
            bready = 1'b0; rready = 1'b0; wlast = 1'b0;
            for (int w = 0; w < 4; w++)
                exp_mem[16'h800 + 16'(w)] = 32'hA0 + 32'(w);
            chk("cont_c0_en", {31'd0, en_log[0]}, 32'd0);
            for (int c = 1; c <= 4; c++) begin
                chk("cont_wr_en", {31'd0, en_log[c]}, 32'd1);
                chk("cont_wr_we", {28'd0, we_log[c]}, 32'hF);
                chk("cont_wr_addr", {16'd0, ad_log[c]},
                    32'h800 + 32'(c - 1));
            end
            chk("cont_rd_en", {31'd0, en_log[5]}, 32'd1);
            chk("cont_rd_we", {28'd0, we_log[5]}, 32'd0);
            chk("cont_rd_addr", {16'd0, ad_log[5]}, 32'h800);
            chk("cont_b_seen", {31'd0, b_seen}, 32'd1);
            chk("cont_r_seen", {31'd0, r_seen}, 32'd1);
            chk("cont_rdata", r_got, 32'hA0);
            chk("cont_mem3", mem[16'h803], 32'hA3);
        end

        // Backpressure and address wrap at the top of the window
        preload(16'hFFFE, 32'hF0E0_0001);
        preload(16'hFFFF, 32'hF0E0_0002);
        preload(16'h0000, 32'hF0E0_0003);
        preload(16'h0001, 32'hF0E0_0004);
        ar_send(4'd6, 32'h0003_FFF8, 8'd3, 3'd2);
        rd_collect(4'd6, 32'h0003_FFF8, 8'd3, 3'd2, 1, got);
        chk("wrap_first", got, 32'hF0E0_0001);

        // Asynchronous reset during the second read beat
        for (int i = 0; i < 4; i++)
            preload(16'h0010 + 16'(i), 32'h5000_0000 + 32'(i));
        ar_send(4'd7, 32'h40, 8'd3, 3'd2);
        begin
            int beats = 0;
            int n = 0;
            bit hit = 1'b0;
            rready = 1'b1;
            while (!hit && n < 100) begin
                @(negedge aclk);
                if (rvalid && beats == 1) begin
                    hit = 1'b1;
                end else begin
                    if (rvalid) beats++;
                    @(posedge aclk); #1;
                    n++;
                end
            end
            chk("rst_mid_reach", {31'd0, hit}, 32'd1);
            #2 aresetn = 1'b0;
            #1;
            chk("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
            chk("rst_mid_ram_en", {31'd0, ram_en}, 32'd0);
            chk("rst_mid_arready", {31'd0, arready}, 32'd1);
            rready = 1'b0;
            @(posedge aclk); #1;
            @(posedge aclk); #1;
            aresetn = 1'b1;
            @(negedge aclk);
            chk("rst_rel_arready", {31'd0, arready}, 32'd1);
            chk("rst_rel_rvalid", {31'd0, rvalid}, 32'd0);
            @(posedge aclk); #1;
        end
        ar_send(4'd8, 32'h40, 8'd1, 3'd2);
        rd_collect(4'd8, 32'h40, 8'd1, 3'd2, 0, got);
        chk("rst_new_read", got, 32'h5000_0000);

        // Randomized bursts around the wrap point
        for (int i = 0; i < 256; i++)
            preload(16'hFFC0 + 16'(i), $urandom);
        for (int t = 0; t < 40; t++) begin
            logic [3:0]  id;
            logic [7:0]  len;
            logic [2:0]  sz;
            logic [31:0] a;
            id  = 4'($urandom % 16);
            len = 8'($urandom % 8);
            sz  = 3'($urandom % 3);
            a   = (32'h0003_FF00 + $urandom_range(0, 32'h1FF)) & BMASK;
            if ($urandom % 2 == 0) begin
                wd_q = {};
                ws_q = {};
                for (int k = 0; k <= int'(len); k++) begin
                    wd_q.push_back($urandom);
                    ws_q.push_back(4'($urandom % 16));
                end
                wr_burst(id, a, len, sz, 1'b1, int'($urandom % 3));
            end else begin
                ar_send(id, a, len, sz);
                rd_collect(id, a, len, sz, 2, got);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
